// File: rtl/dual_slope_capture_if.sv
// rtl/dual_slope_capture_if.sv - result handshake bundle between the capture block and its reader
interface dual_slope_capture_if #(
    parameter int CNT_W = 16
) ();
    logic [CNT_W-1:0] result_o;
    logic             result_sign_o;
    logic [2:0]       result_range_o;
    logic             result_ovr_o;
    logic             result_valid_o;
    logic             result_ready_i;
    logic             result_lost_o;

    modport master (
        output result_o,
        output result_sign_o,
        output result_range_o,
        output result_ovr_o,
        output result_valid_o,
        input  result_ready_i,
        output result_lost_o
    );

    modport slave (
        input  result_o,
        input  result_sign_o,
        input  result_range_o,
        input  result_ovr_o,
        input  result_valid_o,
        output result_ready_i,
        input  result_lost_o
    );
endinterface

// File: rtl/dual_slope_capture.sv
// rtl/dual_slope_capture.sv - dual-slope phase timer, de-integrate capture and result handshake (DS_AVERAGE_EN: 4-conversion averaging)
module dual_slope_capture #(
    parameter int CNT_W      = 16,
    parameter int AZ_CYCLES  = 16,
    parameter int INT_CYCLES = 1000,
    parameter int DEINT_MAX  = 2000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] afe_sel_i,
    input  logic [2:0] range_sel_i,
    input  logic       ref_sign_i,
    input  logic       comp_i,
    input  logic       sat_hi_i,
    input  logic       sat_lo_i,
    output logic       phase_done_o,
    dual_slope_capture_if.master res
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_AZ    = 2'b01,
        S_INT   = 2'b10,
        S_DEINT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] AZ_LAST  = CNT_W'(AZ_CYCLES - 1);
    localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DMAX     = CNT_W'(DEINT_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff, cnt_inc;
    logic             done_q, done_d;
    logic             armed_q, armed_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic             comp0_q;
    logic             sign_cap_q;
    logic [2:0]       range_cap_q;

    logic             entry, new_conv, step_ok;
    logic             crossing, timeout, hit;
    logic             conv_ovr;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             load_ovr;

    logic [CNT_W-1:0] result_q;
    logic             res_sign_q;
    logic [2:0]       res_range_q;
    logic             res_ovr_q;
    logic             valid_q;
    logic             lost_q;

`ifdef DS_AVERAGE_EN
    logic [CNT_W+1:0] acc_q, acc_sum;
    logic [2:0]       acc_n_q, acc_n_d;
    logic             acc_ovr_q, ovr_sum;
    logic             acc_sign_q;
    logic [2:0]       acc_range_q;
    logic             restart;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // state_q doubles as the tracked phase; a mismatch with afe_sel_i marks phase entry
    always_comb begin
        state_d  = state_t'(afe_sel_i);
        entry    = (afe_sel_i != state_q);
        new_conv = entry && (state_d == S_AZ) &&
                   ((state_q == S_IDLE) || (state_q == S_DEINT));
        step_ok  = ((state_q == S_AZ)  && (state_d == S_INT)) ||
                   ((state_q == S_INT) && (state_d == S_DEINT));

        cnt_eff = entry ? '0 : cnt_q;
        cnt_inc = (cnt_eff == CNT_MAX) ? cnt_eff : cnt_eff + CNT_ONE;
        cnt_d   = (state_d == S_IDLE) ? '0 : cnt_inc;

        crossing = 1'b0;
        timeout  = 1'b0;
        if ((state_d == S_DEINT) && !entry && busy_q) begin
            crossing = (comp_i != comp0_q);
            timeout  = !crossing && (cnt_q == DMAX);
        end
        hit = crossing || timeout;

        armed_d = armed_q;
        if (entry) begin
            armed_d = new_conv || (step_ok && armed_q);
        end

        // any entry other than a legal continuation starts a fresh (or aborted) conversion
        ovr_d = ovr_q;
        if (entry && !(step_ok && armed_q)) begin
            ovr_d = 1'b0;
        end
        if ((state_d == S_INT) && armed_d && (sat_hi_i || sat_lo_i)) begin
            ovr_d = 1'b1;
        end

        busy_d = 1'b0;
        if (state_d == S_DEINT) begin
            busy_d = entry ? armed_d : (busy_q && !hit);
        end

        done_d = entry ? 1'b0 : done_q;
        case (state_d)
            S_AZ:    if (cnt_inc >= AZ_LAST)  done_d = 1'b1;
            S_INT:   if (cnt_inc >= INT_LAST) done_d = 1'b1;
            S_DEINT: if (hit)                 done_d = 1'b1;
            default: done_d = 1'b0;
        endcase

        conv_ovr = ovr_q || timeout;

`ifdef DS_AVERAGE_EN
        restart  = (acc_n_q == 3'd0) || (sign_cap_q != acc_sign_q) ||
                   (range_cap_q != acc_range_q);
        acc_sum  = restart ? {2'b00, cnt_q} : acc_q + {2'b00, cnt_q};
        acc_n_d  = restart ? 3'd1 : acc_n_q + 3'd1;
        ovr_sum  = (restart ? 1'b0 : acc_ovr_q) || conv_ovr;
        load     = hit && (acc_n_d == 3'd4);
        load_val = acc_sum[CNT_W+1:2];
        load_ovr = ovr_sum;
`else
        load     = hit;
        load_val = cnt_q;
        load_ovr = conv_ovr;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            done_q      <= 1'b0;
            armed_q     <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
            comp0_q     <= 1'b0;
            sign_cap_q  <= 1'b0;
            range_cap_q <= 3'd0;
        end else begin
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            armed_q <= armed_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
            if (entry && (state_d == S_DEINT)) begin
                comp0_q     <= comp_i;
                sign_cap_q  <= ref_sign_i;
                range_cap_q <= range_sel_i;
            end
        end
    end

`ifdef DS_AVERAGE_EN
    // the accumulator survives aborts; only a completed group or a sign/range change restarts it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            acc_n_q     <= 3'd0;
            acc_ovr_q   <= 1'b0;
            acc_sign_q  <= 1'b0;
            acc_range_q <= 3'd0;
        end else if (hit) begin
            acc_q       <= acc_sum;
            acc_n_q     <= load ? 3'd0 : acc_n_d;
            acc_ovr_q   <= ovr_sum;
            acc_sign_q  <= sign_cap_q;
            acc_range_q <= range_cap_q;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q    <= '0;
            res_sign_q  <= 1'b0;
            res_range_q <= 3'd0;
            res_ovr_q   <= 1'b0;
            valid_q     <= 1'b0;
            lost_q      <= 1'b0;
        end else if (load) begin
            result_q    <= load_val;
            res_sign_q  <= sign_cap_q;
            res_range_q <= range_cap_q;
            res_ovr_q   <= load_ovr;
            valid_q     <= 1'b1;
            if (valid_q && !res.result_ready_i) begin
                lost_q <= 1'b1;
            end
        end else if (valid_q && res.result_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign phase_done_o       = done_q && !entry;
    assign res.result_o       = result_q;
    assign res.result_sign_o  = res_sign_q;
    assign res.result_range_o = res_range_q;
    assign res.result_ovr_o   = res_ovr_q;
    assign res.result_valid_o = valid_q;
    assign res.result_lost_o  = lost_q;

endmodule

// File: doc/dual_slope_capture.md
Name: dual_slope_capture

Overview:
- Timing and measurement responder for the dual-slope conversion controller.
- Watches the AFE phase select driven by the controller and counts the fixed auto-zero and integrate windows.
- Measures the de-integrate time up to the comparator zero crossing, then reports phase completion back to the controller.
- Latches each signed, ranged result and presents it to the downstream reader over a valid/ready handshake.

Parameters:
- CNT_W, 16, width of the phase counter and of result_o.
- AZ_CYCLES, 16, auto-zero window length in clk_i cycles.
- INT_CYCLES, 1000, integrate window length in clk_i cycles.
- DEINT_MAX, 2000, de-integrate timeout in cycles; must be less than 2^CNT_W.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high.
- afe_sel_i  in  2  phase from controller: 00 idle, 01 auto-zero, 10 integrate, 11 de-integrate.
- range_sel_i  in  3  active range; captured with each result.
- ref_sign_i  in  1  reference polarity for de-integrate; captured at de-integrate entry.
- comp_i  in  1  integrator comparator; already synchronous to clk_i.
- sat_hi_i  in  1  integrator high saturation flag.
- sat_lo_i  in  1  integrator low saturation flag.
- phase_done_o  out  1  current phase complete; feeds the controller's counter_done.
- result_o  out  CNT_W  de-integrate count.
- result_sign_o  out  1  captured ref_sign_i.
- result_range_o  out  3  captured range_sel_i.
- result_ovr_o  out  1  overrange: saturation seen, or de-integrate timeout.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  reader accepts the result.
- result_lost_o  out  1  sticky: an unread result was overwritten.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, counter 0, FSM in IDLE, tracked phase 00.
- Internal FSM states: IDLE, AZ, INT, DEINT. Each cycle the state follows afe_sel_i (00/01/10/11 respectively).
- Phase entry is the first cycle in which afe_sel_i differs from the registered tracked phase. In that cycle the counter effectively reads 0. It increments by 1 each following cycle and saturates at 2^CNT_W-1.
- Phase cycle k = counter value + 1.
- phase_done_o = done_flag AND (afe_sel_i == tracked phase). Because of this gating it drops combinationally in the cycle afe_sel_i changes; a stale done never leaks into the next phase.
- AZ: done_flag is set so that phase_done_o is high from phase cycle AZ_CYCLES onward, until the phase changes.
- INT: same rule, with INT_CYCLES. sat_hi_i or sat_lo_i seen in any INT cycle sets the conversion's ovr bit.
- DEINT, entry cycle: sample comp_i as comp0 and capture ref_sign_i and range_sel_i.
- DEINT, crossing: first later cycle with comp_i != comp0. Result = counter value in that cycle. done_flag set; phase_done_o high from the next cycle.
- DEINT, timeout: counter reaches DEINT_MAX with no crossing. Result = DEINT_MAX, ovr set, done_flag set.
- Only one result is produced per DEINT phase. Later comp_i toggles in the same phase are ignored.
- A DEINT phase that ends before crossing or timeout produces no result.
- Abort: afe_sel_i returning to 00, or any unexpected phase order, clears the counter, done_flag and ovr. No result is produced. Completed results already held are kept.
- Result load: the cycle after a crossing or timeout, the result, sign, range and ovr registers update and result_valid_o = 1.
- Handshake:
  - Data stays stable while valid is high and ready is low.
  - valid & ready completes the transfer; valid clears next cycle unless a new load occurs in the same cycle.
  - New load while valid & !ready: overwrite and set result_lost_o.
  - New load with valid & ready in the same cycle: overwrite, valid stays 1, lost is not set.
- result_lost_o clears only on rst_i.

Optional Feature:
- Macro: DS_AVERAGE_EN.
- Defined:
  - Four consecutive conversions are summed into a CNT_W+2 bit accumulator; result_o = sum >> 2 (truncating). Valid asserts once per four conversions.
  - ovr is the OR of the four conversions' ovr bits.
  - sign and range come from the 4th conversion.
  - If range_sel_i or ref_sign_i changes between conversions, the accumulator restarts with the current conversion.
  - Abort does not clear the accumulator.
- Undefined: every conversion loads a result, as above.

Test Plan:
- afe_sel_i 00→01 held 20 cycles -> phase_done_o first high in cycle 16 of the phase; low in the same cycle afe_sel_i changes to 10.
- INT for 1000 cycles, then DEINT with comp_i toggling at counter 437 -> result_o=437, ovr=0, valid=1, and phase_done_o high from the next cycle.
- DEINT with comp_i constant -> at counter 2000: result_o=2000, result_ovr_o=1.
- sat_hi_i pulsed 1 cycle in INT, crossing at 100 -> result_o=100, result_ovr_o=1.
- Two conversions (results 300, then 500) with result_ready_i=0 -> result_o=500, result_lost_o=1. Repeat with ready=1 on the load cycle -> result_lost_o=0.
- afe_sel_i forced to 00 at DEINT counter 50, or rst_i asserted mid-INT -> no valid result, counter 0, and after reset all outputs 0. With DS_AVERAGE_EN, results 100, 101, 102, 104 -> one valid with result_o=101.
